// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder main-memory model.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1, expressed as bit positions.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'b1011_0100_0000_0000;

endpackage

// File: rtl/mem_responder_lfsr16.sv
// 16-bit Fibonacci LFSR, advances every cycle, reloads the seed on rst.
// Only instantiated when MEM_RANDOM_LATENCY_EN is defined.
module lfsr16
    import mem_resp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] o_value
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb    = ^(r_lfsr & LFSR_TAPS);
    assign o_value = r_lfsr;

    // Shift towards the MSB, feedback enters at bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_lfsr <= LFSR_SEED;
        else     r_lfsr <= {r_lfsr[14:0], w_fb};
    end

endmodule

// File: rtl/mem_responder.sv
// Main-memory responder: word-addressed array serving one read or write at a
// time after a programmable latency, with a one-cycle ack pulse.
// Optional: MEM_RANDOM_LATENCY_EN adds 0..7 LFSR-driven extra BUSY cycles.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int OFFSET_SIZE   = 2,
    parameter int DEPTH_LOG2    = 10,
    parameter int LATENCY       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_rd_en,
    input  logic                     mem_wr_en,
    input  logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]    mem_data_out,
    output logic [DATA_WIDTH-1:0]    mem_data_in,
    output logic                     mem_ack,
    output logic                     mem_err
);

    // Wide enough for LATENCY-1 (max 14) plus 7 random extra cycles.
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t                 r_mem [0:(1<<DEPTH_LOG2)-1];
    state_t                r_state, w_state_nxt;
    op_t                   r_op;
    logic [DEPTH_LOG2-1:0] r_idx;
    word_t                 r_wdata, r_rdata;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt, w_cnt_load;
    logic                  r_err;
    logic                  w_req, w_accept, w_to_ack, w_ack;
    logic                  w_unused_addr;

    assign w_req = mem_rd_en | mem_wr_en;
    // Upper bits alias and low offset bits are ignored by design.
    assign w_unused_addr = ^mem_addr;

`ifdef MEM_RANDOM_LATENCY_EN
    logic [15:0] w_lfsr;
    logic        w_unused_lfsr;

    lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .o_value (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[15:3];
    assign w_cnt_load    = LAT_M1 + {{(CNT_W-3){1'b0}}, w_lfsr[2:0]};
`else
    assign w_cnt_load = LAT_M1;
`endif

    // State and latency counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_to_ack    = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = w_cnt_load;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_to_ack    = 1'b1;
                    w_state_nxt = ACK;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ACK: begin
                w_ack       = 1'b1;
                w_state_nxt = RELEASE;
            end
            RELEASE: begin
                // Hold here until the cache drops its request so it is not served twice.
                if (!w_req) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request capture, sticky error, and read data staged for the ACK cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= OP_RD;
            r_idx   <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= mem_wr_en ? OP_WR : OP_RD;   // write wins on conflict
                r_idx   <= mem_addr[OFFSET_SIZE +: DEPTH_LOG2];
                r_wdata <= mem_data_out;
                if (mem_rd_en && mem_wr_en) r_err <= 1'b1;
            end
            if (w_to_ack && r_op == OP_RD) r_rdata <= r_mem[r_idx];
        end
    end

    // Storage array is deliberately not reset; writes commit leaving ACK.
    always_ff @(posedge clk) begin
        if (w_ack && r_op == OP_WR) r_mem[r_idx] <= r_wdata;
    end

    assign mem_ack     = w_ack;
    assign mem_data_in = r_rdata;
    assign mem_err     = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (LATENCY=4). Builds with or without
// MEM_RANDOM_LATENCY_EN; the random-latency block runs only when defined.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd_en = 1'b0;
    logic        mem_wr_en = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_data_out = '0;
    logic [31:0] mem_data_in;
    logic        mem_ack;
    logic        mem_err;

    int errors = 0;
    int checks = 0;

    mem_responder #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .OFFSET_SIZE(2),
        .DEPTH_LOG2(10), .LATENCY(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .mem_ack      (mem_ack),
        .mem_err      (mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Latency counted in edges from the accept edge (inclusive) to the first
    // edge after which mem_ack is seen high: LATENCY+1 = 5 nominally.
    task automatic chk_lat(input string tag, input int lat);
`ifdef MEM_RANDOM_LATENCY_EN
        chk(tag, 32'(lat >= 5 && lat <= 12), 32'd1);
`else
        chk(tag, 32'(lat), 32'd5);
`endif
    endtask

    // Entered at posedge+1 with the DUT idle. Holds the request until ack,
    // keeps it held for 'hold' further cycles counting stray acks, then drops
    // it and lets the FSM return to IDLE.
    task automatic xact(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input int hold,
                        output int lat, output logic [31:0] rdata, output int extra);
        mem_rd_en = rd; mem_wr_en = wr; mem_addr = addr; mem_data_out = data;
        lat = 0; extra = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!mem_ack && lat < 40);
        if (!mem_ack) chk("ack_timeout", 32'(mem_ack), 32'd1);
        rdata = mem_data_in;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (mem_ack) extra++;
        end
        mem_rd_en = 1'b0; mem_wr_en = 1'b0;
        @(posedge clk); #1;
        if (hold == 0) chk("ack_one_cycle", 32'(mem_ack), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat, extra;
        logic [31:0] rd;
        int          d1 [50];

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(mem_ack), 32'd0);
        chk("rst_data", mem_data_in, 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Write AA then read it back
        xact(1'b0, 1'b1, 32'h0, 32'hAAAAAAAA, 0, lat, rd, extra);
        chk_lat("wr_aa_lat", lat);
        chk("wr_aa_err", 32'(mem_err), 32'd0);
        xact(1'b1, 1'b0, 32'h0, 32'h0, 0, lat, rd, extra);
        chk_lat("rd_aa_lat", lat);
        chk("rd_aa_data", rd, 32'hAAAAAAAA);
        chk("rd_aa_err", 32'(mem_err), 32'd0);

        // Two writes, read-back, aliasing; read data must hold across a write
        xact(1'b0, 1'b1, 32'h0, 32'hBBBBBBBB, 0, lat, rd, extra);
        chk("wr_keeps_rdata", rd, 32'hAAAAAAAA);
        xact(1'b0, 1'b1, 32'h4, 32'hCCCCCCCC, 0, lat, rd, extra);
        xact(1'b1, 1'b0, 32'h0, 32'h0, 0, lat, rd, extra);
        chk("rd_0_bb", rd, 32'hBBBBBBBB);
        xact(1'b1, 1'b0, 32'h4, 32'h0, 0, lat, rd, extra);
        chk("rd_4_cc", rd, 32'hCCCCCCCC);
        xact(1'b1, 1'b0, 32'h1000, 32'h0, 0, lat, rd, extra);
        chk("rd_alias", rd, 32'hBBBBBBBB);
        xact(1'b1, 1'b0, 32'h5, 32'h0, 0, lat, rd, extra);
        chk("rd_offset_ign", rd, 32'hCCCCCCCC);

        // Held read: one ack only, then a fresh read still works
        xact(1'b1, 1'b0, 32'h4, 32'h0, 20, lat, rd, extra);
        chk("hold_extra_acks", 32'(extra), 32'd0);
        chk("hold_data", rd, 32'hCCCCCCCC);
        xact(1'b1, 1'b0, 32'h0, 32'h0, 0, lat, rd, extra);
        chk_lat("after_hold_lat", lat);
        chk("after_hold_data", rd, 32'hBBBBBBBB);

        // Both enables: write wins, sticky error
        xact(1'b1, 1'b1, 32'h8, 32'h12345678, 0, lat, rd, extra);
        chk("both_err", 32'(mem_err), 32'd1);
        xact(1'b1, 1'b0, 32'h8, 32'h0, 0, lat, rd, extra);
        chk("both_rd", rd, 32'h12345678);
        chk("err_sticky", 32'(mem_err), 32'd1);

        // Reset mid-write aborts the write
        xact(1'b0, 1'b1, 32'hC, 32'h11111111, 0, lat, rd, extra);
        mem_wr_en = 1'b1; mem_addr = 32'hC; mem_data_out = 32'hDEADBEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_no_ack", 32'(mem_ack), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_ack", 32'(mem_ack), 32'd0);
        chk("abort_err_clr", 32'(mem_err), 32'd0);
        chk("abort_data_clr", mem_data_in, 32'd0);
        mem_wr_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xact(1'b1, 1'b0, 32'hC, 32'h0, 0, lat, rd, extra);
        chk_lat("post_rst_lat", lat);
        chk("post_rst_data", rd, 32'h11111111);

`ifdef MEM_RANDOM_LATENCY_EN
        // Random latency: bounded delays, repeatable after a second reset
        for (int pass = 0; pass < 2; pass++) begin
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            @(posedge clk); #1;
            for (int i = 0; i < 50; i++) begin
                xact(1'b1, 1'b0, 32'hC, 32'h0, 0, lat, rd, extra);
                chk_lat("rand_lat", lat);
                chk("rand_data", rd, 32'h11111111);
                if (pass == 0) d1[i] = lat;
                else chk("rand_repeat", 32'(lat), 32'(d1[i]));
            end
        end
`else
        d1[0] = lat;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
